// File: rtl/pc_gen_pkg.sv
// pc_defs: shared constants and next-PC source encoding for the program
// counter unit of the pipelined MIPS core.
//   DEF_RESET_PC / DEF_EXC_PC / DEF_IMEM_BASE / DEF_IMEM_WORDS : parameter defaults
//   npc_sel_e : which source feeds the PC register on the next clock edge
package pc_defs;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC     = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_BASE  = 32'h0000_3000;
  localparam int          DEF_IMEM_WORDS = 4096;

  // NPC_HOLD covers a stall with no exception/ERET: the PC keeps its value.
  typedef enum logic [2:0] {
    NPC_SEQ  = 3'd0,
    NPC_BR   = 3'd1,
    NPC_JMP  = 3'd2,
    NPC_PEND = 3'd3,
    NPC_ERET = 3'd4,
    NPC_EXC  = 3'd5,
    NPC_HOLD = 3'd6
  } npc_sel_e;

endpackage

// File: rtl/pc_gen_next_mux.sv
// pc_next_mux: combinational next-PC priority select plus the fetch address
// legality check applied to the selected value.
//   Inputs : current PC, stall, branch/jump/exception/ERET requests and
//            targets, pending-redirect flag and target.
//   Outputs: next PC, selected source, PC+4, fetch error of the next PC.
module pc_next_mux
  import pc_defs::*;
#(
  parameter int                 WIDTH      = 32,
  parameter logic [WIDTH-1:0]   EXC_PC     = DEF_EXC_PC[WIDTH-1:0],
  parameter logic [WIDTH-1:0]   IMEM_BASE  = DEF_IMEM_BASE[WIDTH-1:0],
  parameter int                 IMEM_WORDS = DEF_IMEM_WORDS
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic             stall_i,
  input  logic             br_take_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jmp_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             exc_i,
  input  logic             eret_i,
  input  logic [WIDTH-1:0] epc_i,
  input  logic             pend_i,
  input  logic [WIDTH-1:0] pend_target_i,
  output logic [WIDTH-1:0] npc_o,
  output npc_sel_e         sel_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             fetch_err_o
);

  // One extra bit so the end address cannot overflow for IM at the top of memory.
  localparam logic [WIDTH:0] IMEM_END =
    (WIDTH+1)'(IMEM_BASE) + (WIDTH+1)'(4 * IMEM_WORDS);

  // PC+4 wraps modulo 2^WIDTH.
  assign pc_plus4_o = pc_i + WIDTH'(4);

  // Source priority: exception, ERET, stall hold, pending redirect, branch, jump, sequential.
  always_comb begin
    sel_o = NPC_SEQ;
    if (exc_i) begin
      sel_o = NPC_EXC;
    end else if (eret_i) begin
      sel_o = NPC_ERET;
    end else if (stall_i) begin
      sel_o = NPC_HOLD;
    end else if (pend_i) begin
      sel_o = NPC_PEND;
    end else if (br_take_i) begin
      sel_o = NPC_BR;
    end else if (jmp_i) begin
      sel_o = NPC_JMP;
    end else begin
      sel_o = NPC_SEQ;
    end
  end

  // Route the selected source; targets pass through unmodified.
  always_comb begin
    npc_o = pc_plus4_o;
    case (sel_o)
      NPC_EXC:  npc_o = EXC_PC;
      NPC_ERET: npc_o = epc_i;
      NPC_HOLD: npc_o = pc_i;
      NPC_PEND: npc_o = pend_target_i;
      NPC_BR:   npc_o = br_target_i;
      NPC_JMP:  npc_o = jmp_target_i;
      NPC_SEQ:  npc_o = pc_plus4_o;
      default:  npc_o = pc_plus4_o;
    endcase
  end

  // Misaligned, below IM, or at/after the end of IM.
  assign fetch_err_o = (npc_o[1:0] != 2'b00) ||
                       (npc_o < IMEM_BASE) ||
                       ({1'b0, npc_o} >= IMEM_END);

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter for the pipelined MIPS core. Holds the PC,
// a redirect captured while stalled, and a registered fetch-error flag that
// always describes the PC currently presented.
//   Clk, Reset (sync, active high), Stall, Br_take/Br_target, Jmp/Jmp_target,
//   Exc, Eret/Epc -> PC, PC_plus4 (combinational), Fetch_err, Redirect_pending
module pc_gen
  import pc_defs::*;
#(
  parameter int                 WIDTH      = 32,
  parameter logic [WIDTH-1:0]   RESET_PC   = DEF_RESET_PC[WIDTH-1:0],
  parameter logic [WIDTH-1:0]   EXC_PC     = DEF_EXC_PC[WIDTH-1:0],
  parameter logic [WIDTH-1:0]   IMEM_BASE  = DEF_IMEM_BASE[WIDTH-1:0],
  parameter int                 IMEM_WORDS = DEF_IMEM_WORDS
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Br_take,
  input  logic [WIDTH-1:0] Br_target,
  input  logic             Jmp,
  input  logic [WIDTH-1:0] Jmp_target,
  input  logic             Exc,
  input  logic             Eret,
  input  logic [WIDTH-1:0] Epc,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_plus4,
  output logic             Fetch_err,
  output logic             Redirect_pending
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  npc_sel_e         sel;

  pc_next_mux #(
    .WIDTH      (WIDTH),
    .EXC_PC     (EXC_PC),
    .IMEM_BASE  (IMEM_BASE),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_mux (
    .pc_i          (pc_q),
    .stall_i       (Stall),
    .br_take_i     (Br_take),
    .br_target_i   (Br_target),
    .jmp_i         (Jmp),
    .jmp_target_i  (Jmp_target),
    .exc_i         (Exc),
    .eret_i        (Eret),
    .epc_i         (Epc),
    .pend_i        (pend_q),
    .pend_target_i (tgt_q),
    .npc_o         (pc_d),
    .sel_o         (sel),
    .pc_plus4_o    (PC_plus4),
    .fetch_err_o   (err_d)
  );

  // Pending redirect: first branch/jump seen during a stall is captured;
  // exception, ERET or release of the pending target clears it.
  always_comb begin
    pend_d = pend_q;
    tgt_d  = tgt_q;
    case (sel)
      NPC_EXC, NPC_ERET, NPC_PEND: begin
        pend_d = 1'b0;
      end
      NPC_HOLD: begin
        if (!pend_q && (Br_take || Jmp)) begin
          pend_d = 1'b1;
          tgt_d  = Br_take ? Br_target : Jmp_target;
        end else begin
          pend_d = pend_q;
        end
      end
      default: begin
        pend_d = pend_q;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q   <= RESET_PC;
      err_q  <= 1'b0;
      pend_q <= 1'b0;
      tgt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      err_q  <= err_d;
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
    end
  end

  assign PC               = pc_q;
  assign Fetch_err        = err_q;
  assign Redirect_pending = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table plus randomized
// stimulus, both checked against a behavioural reference model.
module tb_pc_gen;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Br_take, Jmp, Exc, Eret;
  logic [31:0] Br_target, Jmp_target, Epc;
  logic [31:0] PC, PC_plus4;
  logic        Fetch_err, Redirect_pending;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_tgt;

  pc_gen dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Br_take(Br_take),
    .Br_target(Br_target), .Jmp(Jmp), .Jmp_target(Jmp_target),
    .Exc(Exc), .Eret(Eret), .Epc(Epc), .PC(PC), .PC_plus4(PC_plus4),
    .Fetch_err(Fetch_err), .Redirect_pending(Redirect_pending)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst, st, br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        ex, er;
    logic [31:0] ep;
    logic [31:0] e_pc;
    logic        e_pend, e_err;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
    return (a % 32'd4 != 32'd0) || (a < 32'h0000_3000) || (a >= 32'h0000_7000);
  endfunction

  // Apply the current inputs for one clock, advance the model, compare.
  task automatic tick();
    logic [31:0] npc;
    logic        npend;
    logic [31:0] ntgt;
    npc = m_pc; npend = m_pend; ntgt = m_tgt;
    if (Reset) begin
      npc = 32'h3000; npend = 1'b0; ntgt = 32'h0;
    end else if (Exc) begin
      npc = 32'h4180; npend = 1'b0;
    end else if (Eret) begin
      npc = Epc; npend = 1'b0;
    end else if (Stall) begin
      if (!m_pend && (Br_take || Jmp)) begin
        npend = 1'b1;
        ntgt  = Br_take ? Br_target : Jmp_target;
      end
    end else if (m_pend) begin
      npc = m_tgt; npend = 1'b0;
    end else if (Br_take) begin
      npc = Br_target;
    end else if (Jmp) begin
      npc = Jmp_target;
    end else begin
      npc = m_pc + 32'd4;
    end
    @(posedge Clk);
    #1;
    m_pc = npc; m_pend = npend; m_tgt = ntgt;
    check("model_pc", PC, m_pc);
    check("model_pc_plus4", PC_plus4, m_pc + 32'd4);
    check("model_fetch_err", {31'd0, Fetch_err}, {31'd0, model_err(m_pc)});
    check("model_pending", {31'd0, Redirect_pending}, {31'd0, m_pend});
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0:       a = 32'h3000 + ($urandom_range(0, 4095) << 2) + $urandom_range(1, 3);
      1:       a = $urandom_range(0, 32'h2FFF);
      2:       a = 32'h7000 + $urandom_range(0, 32'h1000);
      default: a = 32'h3000 + ($urandom_range(0, 4095) << 2);
    endcase
    return a;
  endfunction

  initial begin
    Reset = 1'b1; Stall = 1'b0; Br_take = 1'b0; Jmp = 1'b0; Exc = 1'b0; Eret = 1'b0;
    Br_target = 32'h0; Jmp_target = 32'h0; Epc = 32'h0;
    m_pc = 32'h0; m_pend = 1'b0; m_tgt = 32'h0;

    //          rst   st    br    bt            jp    jt            ex    er    ep            e_pc          pend  err
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h3000,     1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h3004,     1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h3008,     1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h300C,     1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h3010,     1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h3100,    1'b1, 32'h3200,    1'b0, 1'b0, 32'h0,       32'h3100,     1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h3040,    1'b0, 1'b0, 32'h0,       32'h3100,     1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h3080,    1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h3100,     1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h3100,     1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h3999,    1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h3040,     1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h3200,    1'b0, 1'b0, 32'h0,       32'h3040,     1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b0, 32'h0,       32'h4180,     1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h3020,    32'h3020,     1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h3020,    32'h4180,     1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h3002,    1'b0, 1'b0, 32'h0,       32'h3002,     1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h2FFC,    1'b0, 1'b0, 32'h0,       32'h2FFC,     1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h6FFC,    1'b0, 1'b0, 32'h0,       32'h6FFC,     1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h7000,     1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,     32'hFFFF_FFFC, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h3500,    1'b0, 1'b0, 32'h0,       32'h3500,     1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h3300,    1'b0, 1'b0, 32'h0,       32'h3500,     1'b1, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h3000,     1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h3004,     1'b0, 1'b0};

    @(negedge Clk);
    for (int i = 0; i < 24; i++) begin
      Reset = vecs[i].rst; Stall = vecs[i].st; Br_take = vecs[i].br; Br_target = vecs[i].bt;
      Jmp = vecs[i].jp; Jmp_target = vecs[i].jt; Exc = vecs[i].ex; Eret = vecs[i].er;
      Epc = vecs[i].ep;
      tick();
      check($sformatf("vec%0d_pc", i), PC, vecs[i].e_pc);
      check($sformatf("vec%0d_pending", i), {31'd0, Redirect_pending}, {31'd0, vecs[i].e_pend});
      check($sformatf("vec%0d_fetch_err", i), {31'd0, Fetch_err}, {31'd0, vecs[i].e_err});
    end

    // Hand sequence: combinational PC_plus4 follows PC within the cycle and wraps.
    Reset = 1'b0; Stall = 1'b0; Br_take = 1'b0; Exc = 1'b0; Eret = 1'b0;
    Jmp = 1'b1; Jmp_target = 32'hFFFF_FFFC;
    tick();
    check("plus4_wrap", PC_plus4, 32'h0);
    Jmp = 1'b0;

    // Hand sequence: branch beats jump when both arrive during a stall.
    Stall = 1'b1; Br_take = 1'b1; Br_target = 32'h3600; Jmp = 1'b1; Jmp_target = 32'h3700;
    tick();
    Br_take = 1'b0; Jmp = 1'b0; Stall = 1'b0;
    tick();
    check("stall_capture_br_priority", PC, 32'h3600);

    // Randomized phase
    for (int i = 0; i < 2000; i++) begin
      Reset      = ($urandom_range(0, 99) == 0);
      Stall      = ($urandom_range(0, 9) < 4);
      Br_take    = ($urandom_range(0, 9) < 2);
      Jmp        = ($urandom_range(0, 9) < 2);
      Exc        = ($urandom_range(0, 24) == 0);
      Eret       = ($urandom_range(0, 24) == 0);
      Br_target  = rnd_addr();
      Jmp_target = rnd_addr();
      Epc        = rnd_addr();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter unit for the pipelined MIPS core. It supersedes the plain PC register.
- Owns the fetch PC.
- Selects the next PC from sequential, branch, jump, exception-entry and ERET sources.
- Holds under pipeline stall and remembers a redirect that arrives while stalled.
- Flags misaligned or out-of-range fetch addresses for the exception logic.
- Sits at the head of the F stage and feeds IM and the F/D register.

Parameters:
- WIDTH, 32, PC and target width.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_PC, 32'h0000_4180, exception/interrupt handler entry.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_WORDS, 4096, instruction memory size in words.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold PC (from hazard unit).
- Br_take  in  1  branch resolved taken this cycle.
- Br_target  in  WIDTH  branch target.
- Jmp  in  1  j/jal/jr redirect this cycle.
- Jmp_target  in  WIDTH  jump target.
- Exc  in  1  exception/interrupt entry request.
- Eret  in  1  return from exception.
- Epc  in  WIDTH  return address from CP0.
- PC  out  WIDTH  current fetch address.
- PC_plus4  out  WIDTH  PC+4, combinational.
- Fetch_err  out  1  registered; current PC is misaligned or outside IM.
- Redirect_pending  out  1  a redirect captured during stall awaits release.

Behaviour:
- Reset (synchronous, Reset=1 at posedge) overrides everything:
  - PC=RESET_PC.
  - Fetch_err=0.
  - Redirect_pending=0.
  - Pending target register=0.
- Next-PC priority, highest first: Exc, Eret, pending redirect, Br_take, Jmp, PC+4.
- Exc=1: PC<=EXC_PC regardless of Stall; pending cleared. Exc and Eret together: Exc wins.
- Eret=1 (no Exc): PC<=Epc regardless of Stall; pending cleared.
- Stall=1 with no Exc/Eret:
  - PC holds.
  - If Br_take or Jmp is asserted and no redirect is pending, capture the target (Br_target if Br_take, else Jmp_target) and set Redirect_pending=1 next cycle.
  - If a redirect is already pending, later Br_take/Jmp are ignored; the first capture wins.
- Stall=0 with Redirect_pending=1: PC<=pending target, pending cleared next cycle; Br_take/Jmp in that cycle are ignored.
- Stall=0, nothing pending:
  - Br_take: PC<=Br_target.
  - Else Jmp: PC<=Jmp_target.
  - Else PC<=PC+4.
- Arithmetic:
  - PC+4 is modulo 2^WIDTH, so PC=FFFF_FFFC wraps to 0.
  - Targets are loaded unmodified; no masking or alignment.
- Fetch_err is computed from the next-PC value and registered with PC, so it always describes the PC currently presented. It is 1 iff any of:
  - PC[1:0]!=0.
  - PC<IMEM_BASE.
  - PC>=IMEM_BASE+4*IMEM_WORDS.
- Fetch_err does not stop PC advancing; the exception logic responds by asserting Exc.
- PC_plus4 is combinational from PC; latency 0.
- All other outputs change only at posedge: latency 1 from request to new PC.

Decomposition:
- Package pc_defs:
  - Default RESET_PC, EXC_PC, IMEM_BASE, IMEM_WORDS.
  - 3-bit next-PC source encoding: NPC_SEQ, NPC_BR, NPC_JMP, NPC_PEND, NPC_ERET, NPC_EXC.
- One combinational sub-module, pc_next_mux: priority select plus the range/alignment check.
- pc_gen keeps the PC, pending-target and Fetch_err registers.

Test Plan:
- Reset, then 3 free cycles -> PC 3000, 3004, 3008, 300C; Fetch_err=0.
- PC=3010, Br_take=1, Br_target=3100 -> next PC=3100. Same cycle with Jmp=1, Jmp_target=3200 -> still 3100.
- Stall=1 for 3 cycles, Jmp=1 with Jmp_target=3040 in the first -> PC holds and Redirect_pending=1. A Br_take to 3080 in the second is ignored. Stall drops -> PC=3040, pending=0.
- Stall=1 with Exc=1 -> PC=4180 next cycle, pending cleared. Then Eret=1 with Epc=3020 -> PC=3020.
- Jmp_target=3002 -> PC=3002, Fetch_err=1. Jmp_target=2FFC -> Fetch_err=1. Jmp_target=6FFC -> Fetch_err=0. Jmp_target=7000 -> Fetch_err=1.
- Reset asserted mid-stall while a redirect is pending -> PC=3000, pending=0, Fetch_err=0 next cycle.
